// File: rtl/manual_adjust_if.sv
// manual_adjust_if: front-panel keys in, manual carry / set-mode indication out
interface manual_adjust_if;
  logic ModeKey;
  logic IncKey;
  logic Choose;
  logic ib1;
  logic ib2;
  logic ib3;
  logic ib4;
  logic [2:0] SetField;
  modport master (output ModeKey, IncKey, input Choose, ib1, ib2, ib3, ib4, SetField);
  modport slave (input ModeKey, IncKey, output Choose, ib1, ib2, ib3, ib4, SetField);
endinterface

// File: rtl/manual_adjust_ctrl.sv
// manual_adjust_ctrl: debounced Mode/Inc keys driving the RUN/SET mode machine and manual carry pulses
module manual_adjust_ctrl #(
  parameter int DEB_CYC = 20,
  parameter int HOLD_CYC = 500,
  parameter int REP_CYC = 200
) (
  input logic clk,
  input logic rst,
  manual_adjust_if.slave bus
);
  localparam int DW = $clog2(DEB_CYC) + 1;
  localparam int HW = $clog2(HOLD_CYC) + 1;
  localparam int RW = $clog2(REP_CYC) + 1;
  typedef enum logic [2:0] {RUN = 3'd0, SET1 = 3'd1, SET2 = 3'd2, SET3 = 3'd3, SET4 = 3'd4} state_t;
  state_t state_q, state_d;
  logic [1:0] sync1_q, sync2_q, stab_q, stab_d, prev_q, press;
  logic [DW-1:0] deb_cnt_q [2];
  logic [DW-1:0] deb_cnt_d [2];
  logic arm_q, arm_d, rep_q, rep_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [RW-1:0] rep_cnt_q, rep_cnt_d;
  logic choose_q, choose_d;
  logic [3:0] ib_q, ib_d;
  logic mode_press, inc_press, inc_lvl, start, keep, hold_fire, rep_fire, fire;
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      deb_cnt_d[i] = (sync2_q[i] == stab_q[i] || deb_cnt_q[i] == DW'(DEB_CYC)) ? '0 : deb_cnt_q[i] + 1'b1;
      stab_d[i] = (sync2_q[i] != stab_q[i] && deb_cnt_q[i] == DW'(DEB_CYC)) ? sync2_q[i] : stab_q[i];
    end
  end
  assign press = stab_q & ~prev_q;
  assign mode_press = press[0];
  assign inc_press = press[1];
  assign inc_lvl = stab_q[1];
  always_comb begin
    state_d = state_q;
    if (mode_press) state_d = (state_q == SET4) ? RUN : state_t'(state_q + 3'd1);
    choose_d = state_d != RUN;
  end
  always_comb begin
    start = inc_press & (state_q != RUN) & ~mode_press;
    keep = arm_q & inc_lvl & ~mode_press;
    hold_fire = keep & ~rep_q & (hold_cnt_q == HW'(HOLD_CYC - 1));
    rep_fire = keep & rep_q & (rep_cnt_q == RW'(REP_CYC - 1));
    fire = start | hold_fire | rep_fire;
    arm_d = start | keep;
    rep_d = keep & (rep_q | hold_fire);
    hold_cnt_d = (keep & ~rep_q & ~hold_fire) ? hold_cnt_q + 1'b1 : '0;
    rep_cnt_d = (keep & rep_q & ~rep_fire) ? rep_cnt_q + 1'b1 : '0;
    ib_d = fire ? {state_q == SET4, state_q == SET3, state_q == SET2, state_q == SET1} : 4'd0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      sync1_q <= '0;
      sync2_q <= '0;
      stab_q <= '0;
      prev_q <= '0;
      deb_cnt_q[0] <= '0;
      deb_cnt_q[1] <= '0;
      arm_q <= 1'b0;
      rep_q <= 1'b0;
      hold_cnt_q <= '0;
      rep_cnt_q <= '0;
      choose_q <= 1'b0;
      ib_q <= '0;
    end else begin
      state_q <= state_d;
      sync1_q <= {bus.IncKey, bus.ModeKey};
      sync2_q <= sync1_q;
      stab_q <= stab_d;
      prev_q <= stab_q;
      deb_cnt_q <= deb_cnt_d;
      arm_q <= arm_d;
      rep_q <= rep_d;
      hold_cnt_q <= hold_cnt_d;
      rep_cnt_q <= rep_cnt_d;
      choose_q <= choose_d;
      ib_q <= ib_d;
    end
  end
  assign bus.Choose = choose_q;
  assign bus.ib1 = ib_q[0];
  assign bus.ib2 = ib_q[1];
  assign bus.ib3 = ib_q[2];
  assign bus.ib4 = ib_q[3];
  assign bus.SetField = state_q;
endmodule

// File: doc/manual_adjust_ctrl.md
Name: manual_adjust_ctrl

Overview:
Front-panel time-setting controller for the digital clock. It debounces the Mode and Inc keys and runs the RUN/SET mode state machine. In SET modes it drives Choose high and emits single-cycle manual carry pulses on ib1..ib4, which feed the carry-source mux directly upstream of the second/minute/hour/day counter cascade.

Parameters:
DEB_CYC, 20, consecutive stable samples needed to accept a key level change (20 ms at 1 kHz)
HOLD_CYC, 500, cycles an accepted Inc press must be held before auto-repeat starts
REP_CYC, 200, cycles between auto-repeat pulses

Ports:
clk  input  1  system clock, 1 kHz scan clock
rst  input  1  asynchronous active-high reset
ModeKey  input  1  raw Mode button, active-high, asynchronous to clk
IncKey  input  1  raw Inc button, active-high, asynchronous to clk
Choose  output  1  0 = normal carries selected, 1 = manual carries selected
ib1  output  1  manual carry pulse, field 1 (seconds)
ib2  output  1  manual carry pulse, field 2 (minutes)
ib3  output  1  manual carry pulse, field 3 (hours)
ib4  output  1  manual carry pulse, field 4 (day)
SetField  output  3  current state code: 0 = RUN, 1..4 = SETn (drives indicator LEDs)

Behaviour:
- One clock. Reset is asynchronous and active-high. All flops clear on rst: state = RUN, Choose = 0, ib1..ib4 = 0, SetField = 0, synchronizers = 0, debounced levels = 0, all counters = 0.
- Each key uses a 2-flop synchronizer followed by a debouncer. The debouncer counter increments while the synced value differs from the stable value and clears when they match. When the counter reaches DEB_CYC, the stable value takes the synced value and the counter clears.
- A press is a 0->1 transition of a stable value. A release is a 1->0 transition. Bounces shorter than DEB_CYC cycles are never accepted.
- Latency: a raw level held constant from edge k produces its registered press effect (state change or ib pulse) at edge k+DEB_CYC+3.
- State machine: RUN -> SET1 -> SET2 -> SET3 -> SET4 -> RUN. The state advances one step per Mode press and wraps after SET4.
- Choose = 1 in every SETn state and 0 in RUN. Choose and SetField are registered and change on the same edge as the state.
- Inc press in SETn produces exactly one 1-cycle high pulse on ibn. The other ib lines stay 0. At most one ib line is high in any cycle.
- Inc presses in RUN are ignored, and no hold timing starts.
- Auto-repeat: the hold counter starts at an accepted Inc press in SETn. If Inc stays stably high for HOLD_CYC cycles after the press pulse, one extra pulse fires. A further pulse then fires every REP_CYC cycles until release.
- Release clears the hold counter immediately. No pulse fires on release.
- Simultaneous Mode and Inc press in the same cycle: Mode wins, the state advances, and no ib pulse fires. That Inc press is discarded, including its hold timing, until Inc is released and pressed again.
- A Mode press while Inc is held cancels auto-repeat. A new Inc press is then required in the new state.
- Entering RUN from SET4 deasserts Choose on the same edge. No ib pulse may be high in that cycle.
- Reset mid-press: outputs clear immediately. After reset releases, a key still held is seen as a fresh press after full debounce latency, because the debounced level restarts at 0.
- Counters saturate or clear as specified and never wrap into a spurious pulse. Counter widths are sized by $clog2 of the respective parameter plus 1.

Test Plan:
Use DEB_CYC=4, HOLD_CYC=10, REP_CYC=3 for all scenarios.
- Reset: assert rst mid-run with ModeKey held -> Choose=0, SetField=0, ib=0 immediately, asynchronously. After release, ModeKey still high -> SetField=1 at 7 edges after reset deassertion.
- Mode cycling: 5 clean Mode presses, each 20 cycles high and 20 low -> SetField sequence 1,2,3,4,0. Choose is 1 for SetField values 1..4 and returns to 0 on the 5th press.
- Single increment: in SET2, Inc held high for 8 cycles -> exactly one ib2 pulse, 1 cycle wide, at edge k+7. ib1, ib3 and ib4 stay 0.
- Bounce rejection: Inc toggled every 2 cycles for 20 cycles in SET1 -> no ib1 pulse. Then held high for 8 cycles -> exactly one pulse.
- Auto-repeat: in SET3, Inc held 30 cycles -> ib3 pulses at press P, P+10, P+13, P+16, ... Pulses stop after release is accepted, with none on release.
- Conflict and RUN: Mode and Inc rise on the same edge in SET4 -> state goes to RUN, no ib4 pulse. Inc press in RUN -> no ib pulses.
